// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the data-memory access unit: RV32 load/store funct3
// codes, the sequencer state type, the write-back select code that picks the
// shifted memory data, and the store lane-placement helpers.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Write-back select code under which the shifted memory data is chosen.
  localparam logic [2:0] WB_SEL_MEM = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Byte enables for a store. Stores only define SB/SH/SW; every other
  // funct3 behaves as a full-word store.
  function automatic logic [3:0] store_mask(input logic [2:0] f3,
                                            input logic [1:0] lane);
    logic [3:0] mask;
    case (f3)
      F3_LB:   mask = 4'b0001 << lane;
      F3_LH:   mask = 4'b0011 << {lane[1], 1'b0};
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Replicate the right-justified store data across every lane so the
  // memory only has to honour the byte enables.
  function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                              input logic [31:0] data);
    logic [31:0] wdata;
    case (f3)
      F3_LB:   wdata = {4{data[7:0]}};
      F3_LH:   wdata = {2{data[15:0]}};
      default: wdata = data;
    endcase
    return wdata;
  endfunction

  // Natural-alignment check. Loads have unsigned byte/half variants; for
  // stores anything that is not SB/SH is treated as a word access.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic is_byte;
    logic is_half;
    is_byte = (f3 == F3_LB) || (!is_store && (f3 == F3_LBU));
    is_half = (f3 == F3_LH) || (!is_store && (f3 == F3_LHU));
    if (is_byte) return 1'b0;
    if (is_half) return lane[0];
    return (lane != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Word-aligned request/ready data-memory port.
//   mem_req    : request valid (master -> slave)
//   mem_wen    : request is a write
//   mem_addr   : word address, low two bits zero
//   mem_wdata  : lane-replicated write data
//   mem_mask   : byte enables
//   mem_ready  : slave accepted the request (slave -> master)
//   mem_rvalid : read data valid
//   mem_rdata  : read data word
interface mem_access_unit_if;

  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_mask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_mask,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_access_unit_load_extract.sv
// load_extract
// Combinational lane selection and sign/zero extension of a loaded word.
//   rdata  : raw word returned by memory
//   funct3 : RV32 load funct3
//   lane   : byte address bits [1:0]
//   result : extended 32-bit load value
// Reserved funct3 codes return the full word.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A halfword only looks at lane[1]; lane[0] is ignored for halfwords.
  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = rdata[{lane[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h000000, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-memory access sequencer for the execute/memory stage. One load or
// store per start: issue a word-aligned request, wait for read data on a
// load, then lane-align and extend it into o_shifted_mem_data.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_start             : begin an access (only looked at in IDLE)
//   i_is_store          : 1 store, 0 load
//   i_funct3            : RV32 load/store funct3
//   i_addr              : byte address
//   i_store_data        : right-justified store data
//   o_busy              : high whenever not IDLE
//   o_done              : one-cycle completion pulse
//   o_shifted_mem_data  : extended load result, held until next completion
//   o_mem_err           : read response timed out (valid with o_done)
//   o_misaligned        : access trapped as misaligned (valid with o_done)
//   mem                 : memory port (master side)
// Parameter TIMEOUT_CYCLES (>=1): WAIT cycles without read data before an
// error completion.
// Build option MISALIGN_TRAP_EN: when defined, misaligned accesses complete
// immediately with o_misaligned set and issue no memory request.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_shifted_mem_data,
  output logic        o_mem_err,
  output logic        o_misaligned,
  mem_access_unit_if.master mem
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] shifted_q, shifted_d;
  logic        err_q, err_d;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned_q, misaligned_d;
`endif

  logic [31:0] extracted;
  logic        req_c;
  logic        wen_c;
  logic [31:0] mem_addr_c;
  logic [31:0] mem_wdata_c;
  logic [3:0]  mem_mask_c;

  load_extract u_load_extract (
    .rdata  (mem.mem_rdata),
    .funct3 (funct3_q),
    .lane   (addr_q[1:0]),
    .result (extracted)
  );

  // State and captured-request registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      store_data_q <= 32'h0;
      cnt_q        <= '0;
      shifted_q    <= 32'h0;
      err_q        <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      cnt_q        <= cnt_d;
      shifted_q    <= shifted_d;
      err_q        <= err_d;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  // Next-state logic. The bus outputs are only driven in REQ so that the
  // port reads all zeros whenever no request is pending.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    cnt_d        = cnt_q;
    shifted_d    = shifted_q;
    err_d        = err_q;
`ifdef MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif
    req_c        = 1'b0;
    wen_c        = 1'b0;
    mem_addr_c   = 32'h0;
    mem_wdata_c  = 32'h0;
    mem_mask_c   = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          is_store_d   = i_is_store;
          funct3_d     = i_funct3;
          addr_d       = i_addr;
          store_data_d = i_store_data;
          cnt_d        = '0;
          err_d        = 1'b0;
          state_d      = ST_REQ;
`ifdef MISALIGN_TRAP_EN
          misaligned_d = 1'b0;
          if (is_misaligned(i_is_store, i_funct3, i_addr[1:0])) begin
            misaligned_d = 1'b1;
            state_d      = ST_DONE;
          end
`endif
        end
      end

      ST_REQ: begin
        req_c       = 1'b1;
        wen_c       = is_store_q;
        mem_addr_c  = {addr_q[31:2], 2'b00};
        mem_wdata_c = store_wdata(funct3_q, store_data_q);
        mem_mask_c  = store_mask(funct3_q, addr_q[1:0]);
        cnt_d       = '0;
        if (mem.mem_ready) begin
          state_d = is_store_q ? ST_DONE : ST_WAIT;
        end
      end

      // Read data wins over a timeout landing in the same cycle.
      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          shifted_d = extracted;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem.mem_req   = req_c;
  assign mem.mem_wen   = wen_c;
  assign mem.mem_addr  = mem_addr_c;
  assign mem.mem_wdata = mem_wdata_c;
  assign mem.mem_mask  = mem_mask_c;

  assign o_busy             = (state_q != ST_IDLE);
  assign o_done             = (state_q == ST_DONE);
  assign o_shifted_mem_data = shifted_q;
  assign o_mem_err          = err_q;
`ifdef MISALIGN_TRAP_EN
  assign o_misaligned       = misaligned_q;
`else
  assign o_misaligned       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Self-checking bench for mem_access_unit with TIMEOUT_CYCLES = 4. Each
// access is described by its stall plan (ready delay, read-data delay); the
// expected completion cycle, bus values and result come from a
// transaction-level model. A negedge compare process checks the DUT every
// cycle; directed cases pin the model with hand-computed literals.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int T = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_shifted_mem_data;
  logic        o_mem_err;
  logic        o_misaligned;

  mem_access_unit_if mem_bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_start            (i_start),
    .i_is_store         (i_is_store),
    .i_funct3           (i_funct3),
    .i_addr             (i_addr),
    .i_store_data       (i_store_data),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_shifted_mem_data (o_shifted_mem_data),
    .o_mem_err          (o_mem_err),
    .o_misaligned       (o_misaligned),
    .mem                (mem_bus)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  int          txn_cyc = -1;
  int          act_done_cyc = -1;
  logic        done_err, done_mis;
  int          req_cycles = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_mask;

  logic        exp_busy, exp_done, exp_req, exp_wen, exp_err, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_data;
  logic [3:0]  exp_mask;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the load/store rules.
  function automatic logic [31:0] model_load(input logic [31:0] rdata,
                                             input logic [2:0] f3,
                                             input logic [1:0] lane);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * lane)) & 32'hFF;
    h = (rdata >> (16 * lane[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3,
                                            input logic [1:0] lane);
    case (f3)
      3'b000:  return 4'(1 << lane);
      3'b001:  return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3,
                                              input logic [31:0] d);
    case (f3)
      3'b000:  return (d & 32'hFF) * 32'h0101_0101;
      3'b001:  return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic model_mis(input logic st, input logic [2:0] f3,
                                     input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if (f3 == 3'b000 || (!st && f3 == 3'b100)) return 1'b0;
    if (f3 == 3'b001 || (!st && f3 == 3'b101)) return a[0];
    return (a % 4) != 0;
`else
    return (st & 1'b0) | (f3[0] & 1'b0) | (a[0] & 1'b0);
`endif
  endfunction

  // Per-cycle comparison against the model's expected view.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check_output("busy", 32'(o_busy), 32'(exp_busy));
      check_output("done", 32'(o_done), 32'(exp_done));
      check_output("req", 32'(mem_bus.mem_req), 32'(exp_req));
      check_output("data", o_shifted_mem_data, exp_data);
      if (exp_req) begin
        check_output("addr", mem_bus.mem_addr, exp_addr);
        check_output("wen", 32'(mem_bus.mem_wen), 32'(exp_wen));
        if (exp_wen) begin
          check_output("wdata", mem_bus.mem_wdata, exp_wdata);
          check_output("mask", 32'(mem_bus.mem_mask), 32'(exp_mask));
        end
      end
      if (exp_done) begin
        check_output("err", 32'(o_mem_err), 32'(exp_err));
        check_output("misaligned", 32'(o_misaligned), 32'(exp_mis));
      end
      if (o_done) begin
        act_done_cyc = txn_cyc;
        done_err     = o_mem_err;
        done_mis     = o_misaligned;
      end
      if (mem_bus.mem_req) begin
        req_cycles++;
        seen_addr  = mem_bus.mem_addr;
        seen_wdata = mem_bus.mem_wdata;
        seen_mask  = mem_bus.mem_mask;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      txn_cyc = -1;
      i_start = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_req  = 1'b0;
      mem_bus.mem_ready  = 1'($urandom);
      mem_bus.mem_rvalid = 1'($urandom);
      mem_bus.mem_rdata  = $urandom;
    end
  endtask

  // One access: r = cycles ready is held low in REQ, w = WAIT cycles before
  // read data (w >= T means read data never comes).
  task automatic apply_stimulus(input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rd, input int r,
                                input int w);
    int   done_c;
    logic mis;
    mis = model_mis(st, f3, a);
    if (mis)        done_c = 1;
    else if (st)    done_c = 2 + r;
    else if (w < T) done_c = 3 + r + w;
    else            done_c = 2 + r + T;
    act_done_cyc = -1;
    req_cycles   = 0;
    exp_addr  = {a[31:2], 2'b00};
    exp_wen   = st;
    exp_wdata = model_wdata(f3, sd);
    exp_mask  = model_mask(f3, a[1:0]);
    for (int c = 0; c <= done_c; c++) begin
      step();
      txn_cyc = c;
      if (c == 0) begin
        i_start = 1'b1; i_is_store = st; i_funct3 = f3;
        i_addr = a; i_store_data = sd;
        exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
      end else begin
        i_start = 1'($urandom); i_is_store = 1'($urandom);
        i_funct3 = 3'($urandom); i_addr = $urandom; i_store_data = $urandom;
        exp_busy = 1'b1;
        exp_done = (c == done_c);
        exp_req  = !mis && (c <= 1 + r);
      end
      if (c == 1 + r)         mem_bus.mem_ready = 1'b1;
      else if (c >= 1)        mem_bus.mem_ready = (c > 1 + r) ? 1'($urandom) : 1'b0;
      else                    mem_bus.mem_ready = 1'($urandom);
      if (!st && !mis && c >= 2 + r && c < done_c) begin
        mem_bus.mem_rvalid = (w < T) && (c == 2 + r + w);
        mem_bus.mem_rdata  = mem_bus.mem_rvalid ? rd : $urandom;
      end else begin
        mem_bus.mem_rvalid = 1'($urandom);
        mem_bus.mem_rdata  = $urandom;
      end
      if (exp_done) begin
        exp_err = !st && !mis && (w >= T);
        exp_mis = mis;
        if (!st && !mis && w < T) exp_data = model_load(rd, f3, a[1:0]);
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_is_store = 1'b0; i_funct3 = 3'b000;
    i_addr = 32'h0; i_store_data = 32'h0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
    exp_busy = 0; exp_done = 0; exp_req = 0; exp_wen = 0; exp_err = 0; exp_mis = 0;
    exp_addr = 0; exp_wdata = 0; exp_data = 0; exp_mask = 0;
    done_err = 0; done_mis = 0; seen_addr = 0; seen_wdata = 0; seen_mask = 0;
    #12;
    check_output("rst_busy", 32'(o_busy), 32'd0);
    check_output("rst_data", o_shifted_mem_data, 32'd0);
    check_output("rst_req", 32'(mem_bus.mem_req), 32'd0);
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    $display("[TB] directed: LB lane 3");
    apply_stimulus(1'b0, F3_LB, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
    idle(1);
    check_output("lb_latency", act_done_cyc, 32'd3);
    check_output("lb_data", o_shifted_mem_data, 32'hFFFF_FF80);
    check_output("lb_addr", seen_addr, 32'h100);

    $display("[TB] directed: LHU / LH");
    apply_stimulus(1'b0, F3_LHU, 32'h202, 32'h0, 32'hBEEF_0000, 0, 0);
    idle(1);
    check_output("lhu_data", o_shifted_mem_data, 32'h0000_BEEF);
    apply_stimulus(1'b0, F3_LH, 32'h202, 32'h0, 32'hBEEF_0000, 0, 0);
    idle(1);
    check_output("lh_data", o_shifted_mem_data, 32'hFFFF_BEEF);

    $display("[TB] directed: SB with ready stall");
    apply_stimulus(1'b1, F3_LB, 32'h01, 32'h0000_00AB, 32'h0, 3, 0);
    idle(1);
    check_output("sb_wdata", seen_wdata, 32'hABAB_ABAB);
    check_output("sb_mask", 32'(seen_mask), 32'h2);
    check_output("sb_latency", act_done_cyc, 32'd5);
    check_output("sb_req_cycles", req_cycles, 32'd4);

    $display("[TB] directed: load timeout");
    apply_stimulus(1'b0, F3_LW, 32'h300, 32'h0, 32'h1111_2222, 0, T + 2);
    idle(1);
    check_output("to_latency", act_done_cyc, 32'd6);
    check_output("to_err", 32'(done_err), 32'd1);
    check_output("to_data_kept", o_shifted_mem_data, 32'hFFFF_BEEF);

    $display("[TB] directed: LW at 0x06");
    apply_stimulus(1'b0, F3_LW, 32'h06, 32'h0, 32'h1234_5678, 0, 0);
    idle(1);
`ifdef MISALIGN_TRAP_EN
    check_output("lw6_latency", act_done_cyc, 32'd1);
    check_output("lw6_mis", 32'(done_mis), 32'd1);
    check_output("lw6_no_req", req_cycles, 32'd0);
`else
    check_output("lw6_latency", act_done_cyc, 32'd3);
    check_output("lw6_addr", seen_addr, 32'h04);
    check_output("lw6_data", o_shifted_mem_data, 32'h1234_5678);
`endif

    $display("[TB] directed: reset in WAIT");
    step(); txn_cyc = 0;
    i_start = 1'b1; i_is_store = 1'b0; i_funct3 = F3_LW; i_addr = 32'h40;
    exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rvalid = 1'b0;
    step(); txn_cyc = 1;
    i_start = 1'b0; exp_busy = 1'b1; exp_req = 1'b1;
    exp_addr = 32'h40; exp_wen = 1'b0; mem_bus.mem_ready = 1'b1;
    step(); txn_cyc = 2;
    exp_req = 1'b0; mem_bus.mem_ready = 1'b0;
    step(); txn_cyc = 3;
    #2;
    chk_en = 1'b0;
    i_rst = 1'b1;
    #1;
    check_output("arst_busy", 32'(o_busy), 32'd0);
    check_output("arst_done", 32'(o_done), 32'd0);
    check_output("arst_data", o_shifted_mem_data, 32'd0);
    check_output("arst_err", 32'(o_mem_err), 32'd0);
    check_output("arst_req", 32'(mem_bus.mem_req), 32'd0);
    check_output("arst_addr", mem_bus.mem_addr, 32'd0);
    check_output("arst_mask", 32'(mem_bus.mem_mask), 32'd0);
    @(negedge i_clk);
    check_output("arst_no_done", 32'(o_done), 32'd0);
    step();
    i_rst = 1'b0;
    exp_data = 32'h0; exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
    chk_en = 1'b1;
    idle(1);
    apply_stimulus(1'b0, F3_LBU, 32'h81, 32'h0, 32'h0000_C300, 1, 1);
    idle(1);
    check_output("post_rst_latency", act_done_cyc, 32'd5);
    check_output("post_rst_data", o_shifted_mem_data, 32'h0000_00C3);

    $display("[TB] random accesses");
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
